// File: rtl/lms_spi_sequencer.sv
// rtl/lms_spi_sequencer.sv - LMS7002M 32-bit register sequencer over an 8-bit Avalon SPI master core
//
// Purpose: arbitrates two register requesters (A, B) round-robin and turns each
// accepted command into one slave-select framed 4-byte SPI transfer
// {wr, addr[14:0], data[15:0]}, MSB first, by driving the SPI core's register port.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   a_valid/a_ready/a_write/a_addr/a_wdata   requester A command handshake
//   b_valid/b_ready/b_write/b_addr/b_wdata   requester B command handshake
//   rsp_valid, rsp_owner, rsp_rdata, rsp_err completion pulse and held result
//   busy                           frame in progress
//   spi_select, mem_addr, read_n, write_n, data_from_cpu, data_to_cpu
//                                  SPI core register port (strobes active low)
module lms_spi_sequencer #(
  parameter logic [15:0] SLAVE_MASK = 16'h0001,
  parameter int unsigned POLL_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_write,
  input  logic [14:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_write,
  input  logic [14:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        rsp_valid,
  output logic        rsp_owner,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        spi_select,
  output logic [2:0]  mem_addr,
  output logic        read_n,
  output logic        write_n,
  output logic [15:0] data_from_cpu,
  input  logic [15:0] data_to_cpu
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SETSS = 4'd1;
  localparam logic [3:0] S_SSON  = 4'd2;
  localparam logic [3:0] S_PTX   = 4'd3;
  localparam logic [3:0] S_TX    = 4'd4;
  localparam logic [3:0] S_PRX   = 4'd5;
  localparam logic [3:0] S_RX    = 4'd6;
  localparam logic [3:0] S_PTMT  = 4'd7;
  localparam logic [3:0] S_SSOFF = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  // Poll counter value at which the current status read is the last one allowed.
  localparam logic [9:0] POLL_LAST = 10'(POLL_LIMIT - 1);

  logic [3:0]  state;
  logic [1:0]  phase;     // 0,1: strobe low; 2: idle gap before the next access
  logic [1:0]  byte_idx;
  logic [9:0]  poll_cnt;
  logic [31:0] frame;     // shifted left after every transmitted byte
  logic [15:0] rx_shift;  // after 4 bytes holds {byte2, byte3}
  logic [2:0]  stat_q;    // {RRDY, TRDY, TMT} from the last read
  logic        owner;
  logic        is_write;
  logic        err;
  logic        rr_ptr;    // 0 = A has priority on a tie

  logic        grant_a;
  logic        grant_b;
  logic        acc_wr;
  logic [2:0]  acc_addr;
  logic [15:0] acc_wdata;
  logic        poll_hit;
  logic        unused_bits;

  // The core is 8 bits wide; the upper half of its data bus carries nothing.
  assign unused_bits = ^data_to_cpu[15:8];

  assign grant_a   = (state == S_IDLE) && a_valid && (!b_valid || !rr_ptr);
  assign grant_b   = (state == S_IDLE) && b_valid && (!a_valid || rr_ptr);
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign rsp_valid = (state == S_DONE);

  // Every busy state performs exactly one bus access; decode what it is.
  always_comb begin
    acc_wr    = 1'b0;
    acc_addr  = 3'd0;
    acc_wdata = 16'h0000;
    poll_hit  = 1'b0;
    case (state)
      S_SETSS: begin acc_wr = 1'b1; acc_addr = 3'd5; acc_wdata = SLAVE_MASK; end
      S_SSON:  begin acc_wr = 1'b1; acc_addr = 3'd3; acc_wdata = 16'h0400; end
      S_PTX:   begin acc_addr = 3'd2; poll_hit = stat_q[1]; end
      S_TX:    begin acc_wr = 1'b1; acc_addr = 3'd1; acc_wdata = {8'h00, frame[31:24]}; end
      S_PRX:   begin acc_addr = 3'd2; poll_hit = stat_q[2]; end
      S_RX:    acc_addr = 3'd0;
      S_PTMT:  begin acc_addr = 3'd2; poll_hit = stat_q[0]; end
      S_SSOFF: begin acc_wr = 1'b1; acc_addr = 3'd3; acc_wdata = 16'h0000; end
      default: ;
    endcase
  end

  assign spi_select    = busy && (phase != 2'd2);
  assign write_n       = !(spi_select && acc_wr);
  assign read_n        = !(spi_select && !acc_wr);
  assign mem_addr      = spi_select ? acc_addr : 3'd0;
  assign data_from_cpu = (spi_select && acc_wr) ? acc_wdata : 16'h0000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      phase     <= 2'd0;
      byte_idx  <= 2'd0;
      poll_cnt  <= 10'd0;
      frame     <= 32'h0;
      rx_shift  <= 16'h0;
      stat_q    <= 3'b000;
      owner     <= 1'b0;
      is_write  <= 1'b0;
      err       <= 1'b0;
      rr_ptr    <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_rdata <= 16'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          phase <= 2'd0;
          if (grant_a || grant_b) begin
            owner    <= grant_b;
            is_write <= grant_b ? b_write : a_write;
            frame    <= grant_b ? {b_write, b_addr, b_write ? b_wdata : 16'h0000}
                                : {a_write, a_addr, a_write ? a_wdata : 16'h0000};
            err      <= 1'b0;
            byte_idx <= 2'd0;
            if (a_valid && b_valid) rr_ptr <= ~rr_ptr;
            state    <= S_SETSS;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          // Read data is taken on the second edge with the strobe low.
          if (phase == 2'd1) begin
            stat_q <= data_to_cpu[7:5];
            if (state == S_RX) rx_shift <= {rx_shift[7:0], data_to_cpu[7:0]};
          end
          if (phase != 2'd2) begin
            phase <= phase + 2'd1;
          end else begin
            phase <= 2'd0;
            case (state)
              S_SETSS: state <= S_SSON;
              S_SSON: begin
                poll_cnt <= 10'd0;
                state    <= S_PTX;
              end
              S_PTX, S_PRX, S_PTMT: begin
                if (poll_hit) begin
                  state <= (state == S_PTX) ? S_TX : (state == S_PRX) ? S_RX : S_SSOFF;
                end else if (poll_cnt == POLL_LAST) begin
                  // Timeout: always release slave select before reporting.
                  err   <= 1'b1;
                  state <= S_SSOFF;
                end else begin
                  poll_cnt <= poll_cnt + 10'd1;
                end
              end
              S_TX: begin
                frame    <= {frame[23:0], 8'h00};
                poll_cnt <= 10'd0;
                state    <= S_PRX;
              end
              S_RX: begin
                poll_cnt <= 10'd0;
                if (byte_idx == 2'd3) begin
                  state <= S_PTMT;
                end else begin
                  byte_idx <= byte_idx + 2'd1;
                  state    <= S_PTX;
                end
              end
              S_SSOFF: begin
                rsp_owner <= owner;
                rsp_err   <= err;
                rsp_rdata <= (err || is_write) ? 16'h0000 : rx_shift;
                state     <= S_DONE;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lms_spi_sequencer.sv
// tb/tb_lms_spi_sequencer.sv - self-checking bench for lms_spi_sequencer with SPI core model
`timescale 1ns/1ps
module tb_lms_spi_sequencer;

  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, a_ready, a_write;
  logic [14:0] a_addr;
  logic [15:0] a_wdata;
  logic        b_valid, b_ready, b_write;
  logic [14:0] b_addr;
  logic [15:0] b_wdata;
  logic        rsp_valid, rsp_owner, rsp_err, busy;
  logic [15:0] rsp_rdata;
  logic        spi_select, read_n, write_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;

  always #5 clk = ~clk;

  lms_spi_sequencer #(.SLAVE_MASK(16'h0001), .POLL_LIMIT(PL)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .rsp_valid(rsp_valid), .rsp_owner(rsp_owner), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .spi_select(spi_select), .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI core + MISO model
  logic        stub = 1'b0;
  logic        sso = 1'b0;
  logic        rrdy = 1'b0;
  logic [15:0] ssreg = 16'h0;
  int          busy_t = 0;
  logic [7:0]  rx_byte = 8'h0;
  logic [31:0] miso_word = 32'h0;
  int          tx_cnt = 0;
  logic [31:0] mosi = 32'h0;
  int          acc_cnt = 0;
  int          stat_reads = 0;
  logic        ss_bad = 1'b0;
  logic        last_wr = 1'b0;
  logic [2:0]  last_addr = 3'd0;
  logic [15:0] last_data = 16'h0;

  assign data_to_cpu = (mem_addr == 3'd2) ? {8'h00, rrdy, (!stub && (busy_t == 0)), (busy_t == 0), 5'h00}
                     : (mem_addr == 3'd0) ? {8'h00, rx_byte} : 16'h0000;

  // bus monitor state
  int          run = 0;
  logic [2:0]  run_addr;
  logic [15:0] run_data;
  logic        run_wr;

  // requesters and transaction-level model
  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  logic        a_hs = 1'b0, b_hs = 1'b0;
  logic        rr_model = 1'b0;
  logic        exp_owner[$];
  logic [31:0] exp_frame[$];
  logic [15:0] exp_rdata[$];
  logic        exp_err[$];
  logic [5:0]  grant_log = 6'h0;
  int          n_grants = 0;
  int          rsp_count = 0;
  logic        last_owner, last_err;
  logic [15:0] last_rdata;
  logic [31:0] last_mosi;
  int          last_stat_reads, last_acc_cnt;

  initial begin
    logic        exp_o, e_o, e_e;
    logic [31:0] cmd, e_f;
    logic [15:0] e_r;
    a_valid = 0; a_write = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_write = 0; b_addr = 0; b_wdata = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run = 0; sso = 0; ssreg = 0; busy_t = 0; rrdy = 0; tx_cnt = 0;
        a_hs = 0; b_hs = 0; rr_model = 0;
      end else begin
        if (busy_t > 0) begin
          busy_t--;
          if (busy_t == 0) rrdy = 1;
        end
        if (!read_n || !write_n) begin
          run++;
          if (run == 1) begin
            run_addr = mem_addr; run_data = data_from_cpu; run_wr = !write_n;
            chk("acc_start", {spi_select, read_n ^ write_n}, 2'b11);
          end else if (run == 2) begin
            chk("acc_stable", {mem_addr, data_from_cpu, !write_n, spi_select},
                {run_addr, run_data, run_wr, 1'b1});
            acc_cnt++;
            last_wr = run_wr; last_addr = run_addr; last_data = run_data;
            if (run_wr) begin
              if (run_addr == 3'd5) ssreg = run_data;
              if (run_addr == 3'd3) sso = run_data[10];
              if (run_addr == 3'd1) begin
                if (!(sso && ssreg != 16'h0)) ss_bad = 1;
                mosi = {mosi[23:0], run_data[7:0]};
                rx_byte = 8'(miso_word >> (8 * (3 - tx_cnt)));
                tx_cnt++;
                busy_t = 4;
                rrdy = 0;
              end
            end else begin
              if (run_addr == 3'd2) stat_reads++;
              if (run_addr == 3'd0) rrdy = 0;
            end
          end else begin
            chk("strobe_len", run, 2);
          end
        end else if (run > 0) begin
          chk("strobe_len", run, 2);
          chk("gap_select", spi_select, 0);
          run = 0;
        end
      end
      if (a_hs) void'(a_q.pop_front());
      if (b_hs) void'(b_q.pop_front());
      if (a_q.size() > 0) begin a_valid = 1; {a_write, a_addr, a_wdata} = a_q[0]; end
      else begin a_valid = 0; {a_write, a_addr, a_wdata} = 32'h0; end
      if (b_q.size() > 0) begin b_valid = 1; {b_write, b_addr, b_wdata} = b_q[0]; end
      else begin b_valid = 0; {b_write, b_addr, b_wdata} = 32'h0; end
      #1;
      a_hs = 0; b_hs = 0;
      if (reset_n) begin
        a_hs = a_valid && a_ready;
        b_hs = b_valid && b_ready;
        if (busy) chk("no_ready_when_busy", {a_ready, b_ready}, 2'b00);
        if (a_hs || b_hs) begin
          exp_o = (a_valid && b_valid) ? rr_model : b_valid;
          if (a_valid && b_valid) rr_model = !rr_model;
          chk("grant_owner", {a_hs, b_hs}, exp_o ? 2'b01 : 2'b10);
          cmd = exp_o ? b_q[0] : a_q[0];
          exp_owner.push_back(exp_o);
          exp_frame.push_back({cmd[31:16], cmd[31] ? cmd[15:0] : 16'h0});
          exp_rdata.push_back((cmd[31] || stub) ? 16'h0 : miso_word[15:0]);
          exp_err.push_back(stub);
          grant_log = {grant_log[4:0], b_hs};
          n_grants++;
          mosi = 0; tx_cnt = 0; acc_cnt = 0; stat_reads = 0; ss_bad = 0;
        end
        if (rsp_valid) begin
          rsp_count++;
          if (exp_owner.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp: rsp_valid with no outstanding command (owner=%0d)", rsp_owner);
          end else begin
            e_o = exp_owner.pop_front(); e_f = exp_frame.pop_front();
            e_r = exp_rdata.pop_front(); e_e = exp_err.pop_front();
            chk("rsp_owner", rsp_owner, e_o);
            chk("rsp_rdata", rsp_rdata, e_r);
            chk("rsp_err", rsp_err, e_e);
            if (!e_e) begin
              chk("mosi_frame", mosi, e_f);
              chk("tx_bytes", tx_cnt, 4);
            end else begin
              chk("abort_status_reads", stat_reads, PL);
            end
            chk("ss_during_tx", ss_bad, 0);
            chk("ss_released", sso, 0);
            chk("last_access", {last_wr, last_addr, last_data}, {1'b1, 3'd3, 16'h0000});
            last_owner = rsp_owner; last_err = rsp_err; last_rdata = rsp_rdata;
            last_mosi = mosi; last_stat_reads = stat_reads; last_acc_cnt = acc_cnt;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while ((a_q.size() != 0 || b_q.size() != 0 || exp_owner.size() != 0 || busy || rsp_valid)
               && n < max_cyc);
    if (n >= max_cyc) begin
      checks++; failures++;
      $display("FAIL wait_idle: still busy after %0d cycles", n);
    end
  endtask

  initial begin
    int rc;
    int n;
    reset_n = 0;
    repeat (3) @(posedge clk); #2;
    chk("rst_busy", busy, 0);          chk("rst_spi_select", spi_select, 0);
    chk("rst_read_n", read_n, 1);      chk("rst_write_n", write_n, 1);
    chk("rst_mem_addr", mem_addr, 0);  chk("rst_data_from_cpu", data_from_cpu, 0);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_owner", rsp_owner, 0); chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ready", {a_ready, b_ready}, 0);
    reset_n = 1;
    @(posedge clk); #2;

    // Both requesters contending from reset: strict alternation starting at A.
    miso_word = 32'hA5A5_5A5A;
    a_q.push_back({1'b1, 15'h0101, 16'h1111});
    a_q.push_back({1'b0, 15'h0102, 16'h0000});
    a_q.push_back({1'b1, 15'h0103, 16'h3333});
    b_q.push_back({1'b0, 15'h0201, 16'h0000});
    b_q.push_back({1'b1, 15'h0202, 16'hBBBB});
    b_q.push_back({1'b0, 15'h0203, 16'h0000});
    wait_idle(4000);
    chk("arb_order", grant_log, 6'b010101);
    chk("arb_grants", n_grants, 6);
    chk("arb_rsps", rsp_count, 6);

    // A write 0x0020 <= 0x1234
    rc = rsp_count;
    a_q.push_back({1'b1, 15'h0020, 16'h1234});
    wait_idle(1000);
    chk("t1_rsp_count", rsp_count, rc + 1);
    chk("t1_mosi", last_mosi, 32'h8020_1234);
    chk("t1_owner", last_owner, 0);
    chk("t1_err", last_err, 0);
    chk("t1_rdata", last_rdata, 16'h0000);

    // B read 0x002F, MISO returns 0x3840 in bytes 2-3; wdata must not leak into the frame
    miso_word = 32'h0000_3840;
    b_q.push_back({1'b0, 15'h002F, 16'hFFFF});
    wait_idle(1000);
    chk("t2_mosi", last_mosi, 32'h002F_0000);
    chk("t2_rdata", last_rdata, 16'h3840);
    chk("t2_owner", last_owner, 1);
    repeat (5) @(posedge clk); #2;
    chk("t2_rdata_held", rsp_rdata, 16'h3840);
    chk("t2_owner_held", rsp_owner, 1);

    // TRDY never set: POLL_LIMIT status reads, SS released, error response
    stub = 1;
    a_q.push_back({1'b0, 15'h0007, 16'h0000});
    wait_idle(1000);
    stub = 0;
    chk("t3_status_reads", last_stat_reads, 4);
    chk("t3_access_count", last_acc_cnt, 7);
    chk("t3_err", last_err, 1);
    chk("t3_rdata", last_rdata, 16'h0000);
    chk("t3_err_held", rsp_err, 1);

    // Reset in the middle of byte 2
    miso_word = 32'h0;
    a_q.push_back({1'b1, 15'h0011, 16'hBEEF});
    n = 0;
    while (tx_cnt < 3 && n < 2000) begin @(posedge clk); #2; n++; end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL t4_reach_byte2: byte 2 never transmitted");
    end
    repeat (2) @(posedge clk); #2;
    reset_n = 0;
    a_q.delete(); a_valid = 0;
    exp_owner.delete(); exp_frame.delete(); exp_rdata.delete(); exp_err.delete();
    #1;
    chk("t4_busy", busy, 0);           chk("t4_spi_select", spi_select, 0);
    chk("t4_read_n", read_n, 1);       chk("t4_write_n", write_n, 1);
    chk("t4_mem_addr", mem_addr, 0);   chk("t4_data_from_cpu", data_from_cpu, 0);
    chk("t4_rsp_valid", rsp_valid, 0); chk("t4_rsp_err", rsp_err, 0);
    rc = rsp_count;
    repeat (3) @(posedge clk); #2;
    reset_n = 1;
    repeat (20) @(posedge clk); #2;
    chk("t4_no_rsp", rsp_count, rc);
    a_q.push_back({1'b1, 15'h0033, 16'h5678});
    wait_idle(1000);
    chk("t4_after_rsp_count", rsp_count, rc + 1);
    chk("t4_after_mosi", last_mosi, 32'h8033_5678);
    chk("t4_after_owner", last_owner, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
